// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: state encoding, protocol constants and header word indices for the UDP transmit framer
package udp_tx_pkg;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CKSUM   = 3'd1;
    localparam state_t ST_FOLD    = 3'd2;
    localparam state_t ST_HDR     = 3'd3;
    localparam state_t ST_PAYLOAD = 3'd4;
    localparam state_t ST_TAIL    = 3'd5;
    localparam state_t ST_PAD     = 3'd6;
    localparam state_t ST_DONE    = 3'd7;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  PROTO_UDP      = 8'h11;
    localparam logic [8:0]  MIN_FRAME_WORDS = 9'd15;
    localparam logic [8:0] W_ETH0     = 9'd0;
    localparam logic [8:0] W_ETH1     = 9'd1;
    localparam logic [8:0] W_ETH2     = 9'd2;
    localparam logic [8:0] W_ETYPE    = 9'd3;
    localparam logic [8:0] W_IP_LEN   = 9'd4;
    localparam logic [8:0] W_IP_TTL   = 9'd5;
    localparam logic [8:0] W_IP_CKSUM = 9'd6;
    localparam logic [8:0] W_IP_ADDR0 = 9'd7;
    localparam logic [8:0] W_IP_ADDR1 = 9'd8;
    localparam logic [8:0] W_UDP_LEN  = 9'd9;
    localparam logic [8:0] W_PAYLOAD  = 9'd10;
endpackage

// File: rtl/ip_hdr_cksum.sv
// ip_hdr_cksum: one's-complement halfword accumulator; fold collapses carries twice in one cycle
module ip_hdr_cksum (
    input  logic        usr_clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] operand,
    input  logic        fold,
    output logic [15:0] result
);
    logic [19:0] acc;
    logic [16:0] f1;
    logic [15:0] f2;
    assign f1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    assign f2 = f1[15:0] + {15'b0, f1[16]};
    assign result = ~acc[15:0];
    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (fold) acc <= {4'b0, f2};
        else if (add_en) acc <= acc + {4'b0, operand};
    end
endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: builds Ethernet/IPv4/UDP frames from a latched descriptor and a 32-bit payload stream
module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN_WORDS = 366,
    parameter int unsigned TTL = 64
) (
    input  logic        usr_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [47:0] src_mac,
    input  logic [47:0] dst_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [8:0]  len_words,
    input  logic [31:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [31:0] tx_data,
    output logic        tx_sof,
    output logic        tx_we,
    input  logic        tx_stop,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [7:0] TTL_B = 8'(TTL);
    localparam logic [8:0] MAX_LEN = 9'(MAX_LEN_WORDS);
    state_t state, state_nxt;
    logic [8:0] idx, len_q;
    logic [47:0] src_mac_q, dst_mac_q;
    logic [31:0] src_ip_q, dst_ip_q, hdr_word;
    logic [15:0] src_port_q, dst_port_q, ident, carry, ip_len, udp_len, operand, cksum;
    logic accept, bad, emit;
    assign accept = state == ST_IDLE && start;
    assign bad = len_words == 9'd0 || len_words > MAX_LEN;
    assign emit = state == ST_HDR || state == ST_PAYLOAD || state == ST_TAIL || state == ST_PAD;
    assign tx_we = emit && !tx_stop && (state != ST_PAYLOAD || pl_valid);
    assign pl_ready = state == ST_PAYLOAD && !tx_stop;
    assign tx_sof = state == ST_HDR && idx == W_ETH0;
    assign busy = state != ST_IDLE && state != ST_DONE;
    assign done = state == ST_DONE;
    assign ip_len = 16'd28 + {5'b0, len_q, 2'b0};
    assign udp_len = 16'd8 + {5'b0, len_q, 2'b0};

    ip_hdr_cksum u_cksum (
        .usr_clk (usr_clk),
        .reset_n (reset_n),
        .clr     (accept),
        .add_en  (state == ST_CKSUM),
        .operand (operand),
        .fold    (state == ST_FOLD),
        .result  (cksum)
    );

    always_comb begin
        operand = 16'h0;
        case (idx)
            9'd0: operand = {IP_VER_IHL, 8'h00};
            9'd1: operand = ip_len;
            9'd2: operand = ident;
            9'd3: operand = IP_FLAGS_DF;
            9'd4: operand = {TTL_B, PROTO_UDP};
            9'd6: operand = src_ip_q[31:16];
            9'd7: operand = src_ip_q[15:0];
            9'd8: operand = dst_ip_q[31:16];
            9'd9: operand = dst_ip_q[15:0];
            default: operand = 16'h0;
        endcase
    end

    always_comb begin
        hdr_word = 32'h0;
        case (idx)
            W_ETH0:     hdr_word = dst_mac_q[47:16];
            W_ETH1:     hdr_word = {dst_mac_q[15:0], src_mac_q[47:32]};
            W_ETH2:     hdr_word = src_mac_q[31:0];
            W_ETYPE:    hdr_word = {ETHERTYPE_IPV4, IP_VER_IHL, 8'h00};
            W_IP_LEN:   hdr_word = {ip_len, ident};
            W_IP_TTL:   hdr_word = {IP_FLAGS_DF, TTL_B, PROTO_UDP};
            W_IP_CKSUM: hdr_word = {cksum, src_ip_q[31:16]};
            W_IP_ADDR0: hdr_word = {src_ip_q[15:0], dst_ip_q[31:16]};
            W_IP_ADDR1: hdr_word = {dst_ip_q[15:0], src_port_q};
            W_UDP_LEN:  hdr_word = {dst_port_q, udp_len};
            default:    hdr_word = 32'h0;
        endcase
        // payload is shifted by a halfword because the headers end 2 bytes into a word
        tx_data = state == ST_HDR ? hdr_word :
                  state == ST_PAYLOAD ? {(idx == W_PAYLOAD ? 16'h0 : carry), pl_data[31:16]} :
                  state == ST_TAIL ? {carry, 16'h0} : 32'h0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = (start && !bad) ? ST_CKSUM : ST_IDLE;
            ST_CKSUM:   state_nxt = idx == 9'd9 ? ST_FOLD : ST_CKSUM;
            ST_FOLD:    state_nxt = ST_HDR;
            ST_HDR:     state_nxt = (tx_we && idx == W_UDP_LEN) ? ST_PAYLOAD : ST_HDR;
            ST_PAYLOAD: state_nxt = (tx_we && idx == W_UDP_LEN + len_q) ? ST_TAIL : ST_PAYLOAD;
            ST_TAIL:    state_nxt = !tx_we ? ST_TAIL : idx < MIN_FRAME_WORDS - 9'd1 ? ST_PAD : ST_DONE;
            ST_PAD:     state_nxt = (tx_we && idx == MIN_FRAME_WORDS - 9'd1) ? ST_DONE : ST_PAD;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx <= '0;
            len_q <= '0;
            src_mac_q <= '0;
            dst_mac_q <= '0;
            src_ip_q <= '0;
            dst_ip_q <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            ident <= '0;
            carry <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            err <= accept && bad;
            if (accept) begin
                len_q <= len_words;
                src_mac_q <= src_mac;
                dst_mac_q <= dst_mac;
                src_ip_q <= src_ip;
                dst_ip_q <= dst_ip;
                src_port_q <= src_port;
                dst_port_q <= dst_port;
            end
            if (accept || state == ST_FOLD) idx <= '0;
            else if (state == ST_CKSUM || tx_we) idx <= idx + 9'd1;
            if (state == ST_PAYLOAD && tx_we) carry <= pl_data[15:0];
            if (done) ident <= ident + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: byte-level frame model versus udp_tx_framer under stalls, underruns, rejects and resets
module tb_udp_tx_framer;
    localparam logic [7:0] TTL_V = 8'd64;
    logic usr_clk = 1'b0, reset_n = 1'b0, start = 1'b0, pl_valid = 1'b0, tx_stop = 1'b0;
    logic [47:0] src_mac = '0, dst_mac = '0;
    logic [31:0] src_ip = '0, dst_ip = '0, pl_data = '0;
    logic [15:0] src_port = '0, dst_port = '0;
    logic [8:0] len_words = '0;
    logic pl_ready, tx_sof, tx_we, busy, done, err;
    logic [31:0] tx_data;
    logic [31:0] pl_words[$], exp_q[$], got_q[$];
    logic [15:0] exp_ident = '0;
    int tests = 0, fails = 0;

    udp_tx_framer dut (
        .usr_clk(usr_clk), .reset_n(reset_n), .start(start),
        .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .src_port(src_port), .dst_port(dst_port), .len_words(len_words),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_sof(tx_sof), .tx_we(tx_we), .tx_stop(tx_stop),
        .busy(busy), .done(done), .err(err)
    );

    always #5 usr_clk = ~usr_clk;

    // Expected frame assembled as a byte stream, then packed big-endian into words
    function automatic void build(input int n, input logic [47:0] sm, input logic [47:0] dm,
                                  input logic [31:0] si, input logic [31:0] di,
                                  input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] id);
        logic [7:0] b[$];
        logic [7:0] hb[20];
        logic [31:0] s;
        logic [15:0] ipl, udl, ck;
        logic [31:0] p;
        ipl = 16'(28 + 4 * n);
        udl = 16'(8 + 4 * n);
        for (int i = 5; i >= 0; i--) b.push_back(dm[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(sm[i*8 +: 8]);
        b.push_back(8'h08);
        b.push_back(8'h00);
        hb = '{8'h45, 8'h00, ipl[15:8], ipl[7:0], id[15:8], id[7:0], 8'h40, 8'h00, TTL_V, 8'h11,
               8'h00, 8'h00, si[31:24], si[23:16], si[15:8], si[7:0],
               di[31:24], di[23:16], di[15:8], di[7:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0, hb[2*i], hb[2*i+1]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        ck = ~s[15:0];
        hb[10] = ck[15:8];
        hb[11] = ck[7:0];
        foreach (hb[i]) b.push_back(hb[i]);
        b.push_back(sp[15:8]); b.push_back(sp[7:0]);
        b.push_back(dp[15:8]); b.push_back(dp[7:0]);
        b.push_back(udl[15:8]); b.push_back(udl[7:0]);
        b.push_back(8'h00); b.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
            p = pl_words[k];
            b.push_back(p[31:24]); b.push_back(p[23:16]); b.push_back(p[15:8]); b.push_back(p[7:0]);
        end
        while (b.size() % 4 != 0) b.push_back(8'h00);
        while (b.size() < 60) b.push_back(8'h00);
        exp_q.delete();
        for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
    endfunction

    task automatic rand_desc();
        src_mac = 48'({$urandom(), $urandom()});
        dst_mac = 48'({$urandom(), $urandom()});
        src_ip = $urandom();
        dst_ip = $urandom();
        src_port = 16'($urandom());
        dst_port = 16'($urandom());
    endtask

    task automatic rand_payload(input int n);
        pl_words.delete();
        for (int i = 0; i < n; i++) pl_words.push_back($urandom());
    endtask

    task automatic send(input int n, input int stop_a, input int stop_b, input int under_at,
                        input bit rnd, input bit poke, input string name);
        logic [47:0] sm, dm;
        logic [31:0] si, di, prev_data;
        logic [15:0] sp, dp;
        logic prev_sof;
        bit a_used, b_used, u_used, prev_stop, forced_under;
        int wcnt, pcnt, stop_cnt, under_cnt, stalls, done_cyc, first_cyc, bad_idx;
        sm = src_mac; dm = dst_mac; si = src_ip; di = dst_ip; sp = src_port; dp = dst_port;
        build(n, sm, dm, si, di, sp, dp, exp_ident);
        got_q.delete();
        a_used = 0; b_used = 0; u_used = 0; prev_stop = 0; prev_data = '0; prev_sof = 0;
        wcnt = 0; pcnt = 0; stop_cnt = 0; under_cnt = 0; stalls = 0; done_cyc = -1; first_cyc = -1;
        len_words = 9'(n);
        @(posedge usr_clk); #1;
        start = 1'b1;
        @(posedge usr_clk); #1;
        start = 1'b0;
        rand_desc();
        len_words = 9'($urandom());
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            if (stop_cnt == 0 && !a_used && stop_a > 0 && wcnt == stop_a) begin stop_cnt = 5; a_used = 1; end
            if (stop_cnt == 0 && !b_used && stop_b > 0 && wcnt == stop_b) begin stop_cnt = 5; b_used = 1; end
            if (under_cnt == 0 && !u_used && under_at > 0 && pcnt == under_at) begin under_cnt = 3; u_used = 1; end
            forced_under = under_cnt > 0;
            tx_stop = rnd ? ($urandom_range(3) == 0) : (stop_cnt > 0);
            pl_valid = pcnt < n && (rnd ? ($urandom_range(3) != 0) : !forced_under);
            pl_data = pcnt < n ? pl_words[pcnt] : 32'hDEADBEEF;
            if (poke) start = cyc == 5 || cyc == 20;
            if (stop_cnt > 0) begin stop_cnt--; stalls++; end
            if (under_cnt > 0) begin under_cnt--; stalls++; end
            @(negedge usr_clk);
            if (cyc == 1) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_start got %b want 1", name, busy); end
            end
            if (!rnd && tx_stop && prev_stop) begin
                tests++;
                if ({tx_data, tx_sof} !== {prev_data, prev_sof}) begin
                    fails++;
                    $display("FAIL %s stall_hold cyc %0d got %h/%b want %h/%b", name, cyc, tx_data, tx_sof, prev_data, prev_sof);
                end
            end
            if (tx_stop) begin
                tests++;
                if (tx_we !== 1'b0) begin fails++; $display("FAIL %s we_during_stop cyc %0d got %b want 0", name, cyc, tx_we); end
            end
            if (forced_under) begin
                tests++;
                if (tx_we !== 1'b0) begin fails++; $display("FAIL %s we_during_underrun cyc %0d got %b want 0", name, cyc, tx_we); end
            end
            if (poke) begin
                tests++;
                if (err !== 1'b0) begin fails++; $display("FAIL %s err_while_busy cyc %0d got %b want 0", name, cyc, err); end
            end
            if (tx_we === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                tests++;
                if (tx_sof !== (wcnt == 0)) begin fails++; $display("FAIL %s sof word %0d got %b want %b", name, wcnt, tx_sof, wcnt == 0); end
                got_q.push_back(tx_data);
                wcnt++;
            end
            if (pl_valid && pl_ready) pcnt++;
            prev_stop = tx_stop; prev_data = tx_data; prev_sof = tx_sof;
            if (done === 1'b1) begin done_cyc = cyc; break; end
            @(posedge usr_clk); #1;
        end
        start = 1'b0; tx_stop = 1'b0; pl_valid = 1'b0;
        tests++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL %s done_timeout got no done want done", name);
        end else begin
            exp_ident++;
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
            if (!rnd) begin
                tests++;
                if (done_cyc != 12 + exp_q.size() + stalls) begin
                    fails++;
                    $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, 12 + exp_q.size() + stalls);
                end
                tests++;
                if (first_cyc != 12) begin fails++; $display("FAIL %s first_write_cycle got %0d want 12", name, first_cyc); end
            end
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s word_count got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        bad_idx = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin bad_idx = i; break; end
        tests++;
        if (bad_idx >= 0) begin
            fails++;
            $display("FAIL %s frame_word %0d got %h want %h", name, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
        end
    endtask

    task automatic test_reset();
        @(negedge usr_clk);
        tests++;
        if ({tx_we, tx_sof, tx_data, busy, done, err, pl_ready} !== 38'h0) begin
            fails++;
            $display("FAIL reset_outputs got we%b sof%b data%h busy%b done%b err%b rdy%b want all 0", tx_we, tx_sof, tx_data, busy, done, err, pl_ready);
        end
        @(posedge usr_clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge usr_clk);
        tests++;
        if ({tx_we, tx_sof, tx_data, busy, done, err, pl_ready} !== 38'h0) begin
            fails++;
            $display("FAIL idle_outputs got we%b sof%b data%h busy%b done%b err%b rdy%b want all 0", tx_we, tx_sof, tx_data, busy, done, err, pl_ready);
        end
    endtask

    task automatic test_cksum();
        rand_desc();
        src_ip = 32'hC0A80102;
        dst_ip = 32'hC0A80101;
        rand_payload(4);
        send(4, 0, 0, 0, 0, 0, "cksum");
        tests++;
        if (got_q.size() != 15) begin fails++; $display("FAIL cksum_len got %0d want 15", got_q.size()); end
        else begin
            tests++;
            if (got_q[4] !== 32'h002C0000) begin fails++; $display("FAIL cksum_w4 got %h want 002c0000", got_q[4]); end
            tests++;
            if (got_q[6] !== 32'hB76DC0A8) begin fails++; $display("FAIL cksum_w6 got %h want b76dc0a8", got_q[6]); end
        end
    endtask

    task automatic test_min_pad();
        rand_desc();
        pl_words.delete();
        pl_words.push_back(32'h11223344);
        send(1, 0, 0, 0, 0, 0, "min_pad");
        tests++;
        if (got_q.size() != 15) begin fails++; $display("FAIL pad_len got %0d want 15", got_q.size()); end
        else begin
            tests++;
            if ({got_q[10], got_q[11]} !== 64'h00001122_33440000) begin
                fails++;
                $display("FAIL pad_payload got %h %h want 00001122 33440000", got_q[10], got_q[11]);
            end
            tests++;
            if ({got_q[12], got_q[13], got_q[14]} !== 96'h0) begin
                fails++;
                $display("FAIL pad_zero got %h %h %h want 0", got_q[12], got_q[13], got_q[14]);
            end
        end
    endtask

    task automatic test_backpressure();
        rand_desc();
        rand_payload(4);
        send(4, 3, 12, 0, 0, 0, "backpressure");
    endtask

    task automatic test_underrun();
        rand_desc();
        rand_payload(8);
        send(8, 0, 0, 3, 0, 0, "underrun");
    endtask

    task automatic test_reject();
        int lens[2] = '{0, 367};
        logic [15:0] id0;
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            len_words = 9'(lens[i]);
            @(posedge usr_clk); #1;
            start = 1'b1;
            @(posedge usr_clk); #1;
            start = 1'b0;
            @(negedge usr_clk);
            tests++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reject_%0d_pulse got err%b busy%b want err1 busy0", lens[i], err, busy);
            end
            @(negedge usr_clk);
            tests++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reject_%0d_after got err%b busy%b want err0 busy0", lens[i], err, busy);
            end
        end
        rand_desc();
        rand_payload(366);
        id0 = exp_ident;
        send(366, 0, 0, 0, 0, 0, "max_len");
        tests++;
        if (got_q.size() != 377) begin fails++; $display("FAIL max_len_count got %0d want 377", got_q.size()); end
        w = got_q.size() > 4 ? got_q[4] : 32'hx;
        tests++;
        if (w !== {16'h05D4, id0}) begin fails++; $display("FAIL max_len_w4 got %h want %h", w, {16'h05D4, id0}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2;
        int n;
        n = $urandom_range(1, 12);
        rand_desc();
        rand_payload(n);
        send(n, 0, 0, 0, 0, 1, "b2b_first");
        w1 = got_q.size() > 4 ? got_q[4] : 32'hx;
        n = $urandom_range(1, 12);
        rand_desc();
        rand_payload(n);
        send(n, 0, 0, 0, 0, 0, "b2b_second");
        w2 = got_q.size() > 4 ? got_q[4] : 32'hx;
        tests++;
        if (w2[15:0] !== w1[15:0] + 16'd1) begin
            fails++;
            $display("FAIL b2b_ident got %h want %h", w2[15:0], w1[15:0] + 16'd1);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 40);
            rand_desc();
            rand_payload(n);
            send(n, 0, 0, 0, 1, 0, "random");
        end
    endtask

    task automatic test_reset_midframe();
        int wcnt;
        logic [31:0] w;
        wcnt = 0;
        rand_desc();
        len_words = 9'd5;
        tx_stop = 1'b0;
        pl_valid = 1'b0;
        @(posedge usr_clk); #1;
        start = 1'b1;
        @(posedge usr_clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge usr_clk);
            if (tx_we === 1'b1) wcnt++;
            if (wcnt == 7) break;
        end
        tests++;
        if (wcnt != 7) begin fails++; $display("FAIL midframe_reach_w7 got %0d writes want 7", wcnt); end
        @(posedge usr_clk); #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({tx_we, tx_sof, tx_data, busy, done, err, pl_ready} !== 38'h0) begin
            fails++;
            $display("FAIL midframe_reset_outputs got we%b sof%b data%h busy%b done%b err%b rdy%b want all 0", tx_we, tx_sof, tx_data, busy, done, err, pl_ready);
        end
        repeat (2) @(posedge usr_clk);
        #1;
        reset_n = 1'b1;
        exp_ident = '0;
        rand_desc();
        rand_payload(2);
        send(2, 0, 0, 0, 0, 0, "after_reset");
        w = got_q.size() > 4 ? got_q[4] : 32'hx;
        tests++;
        if (w[15:0] !== 16'h0) begin fails++; $display("FAIL after_reset_ident got %h want 0000", w[15:0]); end
    endtask

    initial begin
        test_reset();
        test_cksum();
        test_min_pad();
        test_backpressure();
        test_underrun();
        test_reject();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
